// File: rtl/exc_arbiter.sv
// Exception/interrupt arbiter: fixed-priority pick of sync faults and masked IRQs into a latched cause.
// Latency: source at edge N -> exc_req_o/cause_o after edge N; EXC_IRQ_LATCH_EN adds an edge-capture pending stage.
// Backpressure: exc_req_o is held with a frozen cause until exc_ack_i; interrupts are blocked until eret_i.
module exc_arbiter #(
    parameter int N_IRQ = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             illegal_insn_i,
    input  logic             ecall_insn_i,
    input  logic             ebrk_insn_i,
    input  logic             flush_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             irq_enable_i,
    input  logic             mask_we_i,
    input  logic [N_IRQ-1:0] mask_wdata_i,
    input  logic             exc_ack_i,
    input  logic             eret_i,
    output logic             exc_req_o,
    output logic [5:0]       cause_o,
    output logic [N_IRQ-1:0] mask_o,
    output logic             in_handler_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HANDLER = 2'd2
    } state_t;

    state_t             state_q;
    logic [5:0]         cause_q;
    logic [N_IRQ-1:0]   mask_q;
    logic               exc_req_q;
    logic               in_handler_q;

    logic [N_IRQ-1:0]   irq_src;
    logic [N_IRQ-1:0]   irq_qual;
    logic               irq_any;
    logic [4:0]         irq_idx;
    logic               sync_any;
    logic [4:0]         sync_code;

`ifdef EXC_IRQ_LATCH_EN
    localparam logic [N_IRQ-1:0] IRQ_ONE = 1;

    logic [N_IRQ-1:0]   irq_prev_q;
    logic [N_IRQ-1:0]   pending_q;
    logic [N_IRQ-1:0]   pend_clr;

    // The taken interrupt's pending bit drops on the accepted ack; a fresh edge that cycle re-arms it.
    always_comb begin
        pend_clr = '0;
        if (state_q == ST_REQ && exc_ack_i && cause_q[5])
            pend_clr = IRQ_ONE << cause_q[4:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= irq_i;
            pending_q  <= (pending_q & ~pend_clr) | (irq_i & ~irq_prev_q);
        end
    end

    assign irq_src = pending_q;
`else
    assign irq_src = irq_i;
`endif

    assign irq_qual = irq_src & mask_q & {N_IRQ{irq_enable_i}};
    assign irq_any  = |irq_qual;
    assign sync_any = illegal_insn_i | ecall_insn_i | ebrk_insn_i;

    always_comb begin
        if (illegal_insn_i)
            sync_code = 5'd2;
        else if (ecall_insn_i)
            sync_code = 5'd11;
        else
            sync_code = 5'd3;
    end

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        irq_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_qual[i])
                irq_idx = 5'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cause_q      <= '0;
            mask_q       <= '0;
            exc_req_q    <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            if (mask_we_i)
                mask_q <= mask_wdata_i;

            case (state_q)
                ST_IDLE: begin
                    if (sync_any && !flush_i) begin
                        state_q   <= ST_REQ;
                        cause_q   <= {1'b0, sync_code};
                        exc_req_q <= 1'b1;
                    end else if (irq_any) begin
                        state_q   <= ST_REQ;
                        cause_q   <= {1'b1, irq_idx};
                        exc_req_q <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (exc_ack_i) begin
                        state_q      <= ST_HANDLER;
                        exc_req_q    <= 1'b0;
                        in_handler_q <= 1'b1;
                    end else if (flush_i && !cause_q[5]) begin
                        // Only a synchronous cause dies with the killed ID instruction.
                        state_q   <= ST_IDLE;
                        exc_req_q <= 1'b0;
                    end
                end

                ST_HANDLER: begin
                    if (sync_any && !flush_i) begin
                        state_q      <= ST_REQ;
                        cause_q      <= {1'b0, sync_code};
                        exc_req_q    <= 1'b1;
                        in_handler_q <= 1'b0;
                    end else if (eret_i) begin
                        state_q      <= ST_IDLE;
                        in_handler_q <= 1'b0;
                    end
                end

                default: begin
                    state_q      <= ST_IDLE;
                    exc_req_q    <= 1'b0;
                    in_handler_q <= 1'b0;
                end
            endcase
        end
    end

    assign exc_req_o    = exc_req_q;
    assign cause_o      = cause_q;
    assign mask_o       = mask_q;
    assign in_handler_o = in_handler_q;

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed vector bench for exc_arbiter: table of per-cycle stimulus with expected registered outputs.
module tb_exc_arbiter;

    localparam int N = 16;

    logic          clk;
    logic          rst;
    logic          illegal_insn_i;
    logic          ecall_insn_i;
    logic          ebrk_insn_i;
    logic          flush_i;
    logic [N-1:0]  irq_i;
    logic          irq_enable_i;
    logic          mask_we_i;
    logic [N-1:0]  mask_wdata_i;
    logic          exc_ack_i;
    logic          eret_i;
    logic          exc_req_o;
    logic [5:0]    cause_o;
    logic [N-1:0]  mask_o;
    logic          in_handler_o;

    int checks;
    int failures;

    exc_arbiter #(.N_IRQ(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .illegal_insn_i (illegal_insn_i),
        .ecall_insn_i   (ecall_insn_i),
        .ebrk_insn_i    (ebrk_insn_i),
        .flush_i        (flush_i),
        .irq_i          (irq_i),
        .irq_enable_i   (irq_enable_i),
        .mask_we_i      (mask_we_i),
        .mask_wdata_i   (mask_wdata_i),
        .exc_ack_i      (exc_ack_i),
        .eret_i         (eret_i),
        .exc_req_o      (exc_req_o),
        .cause_o        (cause_o),
        .mask_o         (mask_o),
        .in_handler_o   (in_handler_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         rst;
        logic         ill;
        logic         ecall;
        logic         ebrk;
        logic         flush;
        logic [N-1:0] irq;
        logic         en;
        logic         we;
        logic [N-1:0] wdata;
        logic         ack;
        logic         eret;
        logic         exp_req;
        logic [5:0]   exp_cause;
        logic [N-1:0] exp_mask;
        logic         exp_inh;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic il, logic ec, logic eb, logic fl,
                                logic [N-1:0] iq, logic en, logic we, logic [N-1:0] wd,
                                logic ak, logic er,
                                logic xreq, logic [5:0] xcause, logic [N-1:0] xmask, logic xinh);
        vec_t v;
        v.rst = r; v.ill = il; v.ecall = ec; v.ebrk = eb; v.flush = fl;
        v.irq = iq; v.en = en; v.we = we; v.wdata = wd; v.ack = ak; v.eret = er;
        v.exp_req = xreq; v.exp_cause = xcause; v.exp_mask = xmask; v.exp_inh = xinh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        illegal_insn_i = v.ill;
        ecall_insn_i   = v.ecall;
        ebrk_insn_i    = v.ebrk;
        flush_i        = v.flush;
        irq_i          = v.irq;
        irq_enable_i   = v.en;
        mask_we_i      = v.we;
        mask_wdata_i   = v.wdata;
        exc_ack_i      = v.ack;
        eret_i         = v.eret;
    endtask

    task automatic step_and_check(input string tag, input logic xreq, input logic [5:0] xcause,
                                  input logic [N-1:0] xmask, input logic xinh);
        @(posedge clk);
        #1;
        check({tag, ".req"},   32'(exc_req_o),    32'(xreq));
        check({tag, ".cause"}, 32'(cause_o),      32'(xcause));
        check({tag, ".mask"},  32'(mask_o),       32'(xmask));
        check({tag, ".inh"},   32'(in_handler_o), 32'(xinh));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

`ifndef EXC_IRQ_LATCH_EN
        //            rst il ec eb fl irq      en we wdata    ak er   req cause  mask     inh
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 6'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 1, 16'h0004, 0, 0,  0, 6'h00, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0004, 1, 0, 16'h0000, 0, 0,  1, 6'h22, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0,  0, 6'h22, 16'h0004, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,  0, 6'h22, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 1, 16'h0007, 0, 0,  0, 6'h22, 16'h0007, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0001, 1, 0, 16'h0000, 0, 0,  1, 6'h02, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0001, 1, 0, 16'h0000, 0, 0,  0, 6'h02, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0001, 1, 0, 16'h0000, 0, 0,  1, 6'h20, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0,  0, 6'h20, 16'h0007, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0002, 1, 0, 16'h0000, 0, 0,  0, 6'h20, 16'h0007, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0002, 1, 0, 16'h0000, 0, 1,  0, 6'h20, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0002, 1, 0, 16'h0000, 0, 0,  1, 6'h21, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0,  0, 6'h21, 16'h0007, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,  1, 6'h0B, 16'h0007, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 1, 0, 16'h0000, 1, 0,  0, 6'h0B, 16'h0007, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,  0, 6'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0004, 1, 0, 16'h0000, 0, 0,  0, 6'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'hFFFF, 0, 1, 16'hFFFF, 0, 0,  0, 6'h00, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h8000, 0, 0, 16'h0000, 0, 0,  0, 6'h00, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h8000, 1, 0, 16'h0000, 0, 0,  1, 6'h2F, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 1, 0, 16'h0000, 0, 0,  1, 6'h2F, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0,  0, 6'h2F, 16'hFFFF, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h0000, 1, 0, 16'h0000, 0, 0,  0, 6'h2F, 16'hFFFF, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,  1, 6'h03, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,  1, 6'h03, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0,  0, 6'h03, 16'hFFFF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0,  0, 6'h03, 16'hFFFF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,  0, 6'h03, 16'hFFFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h8004, 1, 0, 16'h0000, 0, 0,  1, 6'h22, 16'hFFFF, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h8004, 1, 0, 16'h0000, 0, 0,  0, 6'h00, 16'h0000, 0));
`else
        //            rst il ec eb fl irq      en we wdata    ak er   req cause  mask     inh
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 6'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,  0, 6'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0020, 1, 0, 16'h0000, 0, 0,  0, 6'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,  0, 6'h00, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 1, 16'h0020, 0, 0,  0, 6'h00, 16'h0020, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,  1, 6'h25, 16'h0020, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0,  0, 6'h25, 16'h0020, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1,  0, 6'h25, 16'h0020, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,  0, 6'h25, 16'h0020, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,  0, 6'h25, 16'h0020, 0));
`endif

        foreach (vecs[k]) begin
            drive(vecs[k]);
            step_and_check($sformatf("vec%0d", k), vecs[k].exp_req, vecs[k].exp_cause,
                           vecs[k].exp_mask, vecs[k].exp_inh);
        end

`ifndef EXC_IRQ_LATCH_EN
        // Cause stays frozen in REQ while every other source churns.
        rst = 1'b0; illegal_insn_i = 1'b0; ecall_insn_i = 1'b0; ebrk_insn_i = 1'b0;
        flush_i = 1'b0; irq_i = '0; irq_enable_i = 1'b1; exc_ack_i = 1'b0; eret_i = 1'b0;
        mask_we_i = 1'b1; mask_wdata_i = 16'h00FF;
        step_and_check("seq_mask", 1'b0, 6'h00, 16'h00FF, 1'b0);
        mask_we_i = 1'b0;
        illegal_insn_i = 1'b1;
        step_and_check("seq_ill", 1'b1, 6'h02, 16'h00FF, 1'b0);
        illegal_insn_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ecall_insn_i = i[0];
            ebrk_insn_i  = i[1];
            irq_i        = 16'h0001 << i;
            step_and_check($sformatf("seq_frozen%0d", i), 1'b1, 6'h02, 16'h00FF, 1'b0);
        end
        ecall_insn_i = 1'b0; ebrk_insn_i = 1'b0; irq_i = '0;
        exc_ack_i = 1'b1;
        step_and_check("seq_ack", 1'b0, 6'h02, 16'h00FF, 1'b1);
        exc_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            irq_i = 16'h00FF;
            step_and_check($sformatf("seq_blocked%0d", i), 1'b0, 6'h02, 16'h00FF, 1'b1);
        end
        irq_i = '0; eret_i = 1'b1;
        step_and_check("seq_eret", 1'b0, 6'h02, 16'h00FF, 1'b0);
        eret_i = 1'b0;
        step_and_check("seq_idle", 1'b0, 6'h02, 16'h00FF, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_arbiter.md
# exc_arbiter

Exception and interrupt arbiter placed in front of the main CPU controller. It collects synchronous exception flags from the decoder and level interrupt lines from the platform, and selects one winner by fixed priority. It presents the winner to the controller as a registered `exc_req_o`/`exc_ack_i` handshake with a latched cause code. Until the handler executes `eret`, it blocks further interrupts.

## Interface
- `N_IRQ`, default 16: number of interrupt lines, 1..31.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `illegal_insn_i` in 1: decoder flags an illegal instruction in ID.
- `ecall_insn_i` in 1: decoder flags an ecall in ID.
- `ebrk_insn_i` in 1: decoder flags an ebreak in ID.
- `flush_i` in 1: the ID instruction is being killed (taken branch in EX).
- `irq_i` in N_IRQ: interrupt lines, level-sensitive unless `EXC_IRQ_LATCH_EN` is defined.
- `irq_enable_i` in 1: global interrupt enable.
- `mask_we_i` in 1: write strobe for the interrupt mask register.
- `mask_wdata_i` in N_IRQ: mask write data; 1 means enabled.
- `exc_ack_i` in 1: controller has taken the exception and redirected the PC.
- `eret_i` in 1: eret decoded and executing in ID.
- `exc_req_o` out 1: exception request to the controller.
- `cause_o` out 6: bit 5 is 1 for interrupts and 0 for synchronous exceptions; bits 4:0 hold the code.
- `mask_o` out N_IRQ: current mask register.
- `in_handler_o` out 1: the core is inside a handler.

## Operation
- States:
  - IDLE: no request; normal execution.
  - REQ: request held until acknowledged.
  - HANDLER: handler running; interrupts blocked.
- Qualified interrupt vector: `irq_q = irq_src & mask_q & {N_IRQ{irq_enable_i}}`.
  - `irq_src` is `irq_i`, or the pending vector when `EXC_IRQ_LATCH_EN` is defined.
- Priority and codes, highest first:
  - illegal instruction, code 2;
  - ecall, code 11;
  - ebreak, code 3;
  - lowest-index set bit of `irq_q`, code equal to the index.
- IDLE transitions:
  - Any source present and `flush_i` low: go to REQ and latch the winner into `cause_q`.
  - `flush_i` high: synchronous sources are ignored that cycle; interrupts are still eligible.
- REQ transitions:
  - The cause is frozen; new sources do not change it.
  - `exc_ack_i` high: go to HANDLER.
  - `flush_i` high with no ack and a synchronous cause (bit 5 = 0): go to IDLE and drop the request.
  - `flush_i` does not cancel an interrupt cause.
  - `exc_ack_i` and `flush_i` high in the same cycle: ack wins.
- HANDLER transitions:
  - All interrupts are ignored.
  - A synchronous source with `flush_i` low goes to REQ with a new cause (nested fault).
  - Otherwise `eret_i` goes to IDLE.
  - `eret_i` and a synchronous source in the same cycle: the synchronous source wins.
- Mask register:
  - Writing `mask_we_i` loads `mask_wdata_i` at the next edge, in any state.
  - The new mask first affects qualification the cycle after the write.
- Unused encodings decode to IDLE.

## Timing
- Reset values: state IDLE, `exc_req_o` 0, `cause_o` 0, `mask_o` 0 (all masked), `in_handler_o` 0, pending vector 0.
- Latency:
  - A source sampled at edge N gives `exc_req_o` = 1 and a valid `cause_o` after edge N.
  - So the request is visible in the cycle following the source, one cycle of latency.
- `exc_req_o` is exactly (state == REQ) and is driven from a register with no combinational input path.
- `exc_ack_i` sampled high at edge M gives `exc_req_o` = 0 and `in_handler_o` = 1 after edge M.
- `cause_o` holds its value from REQ entry through HANDLER until the next REQ entry.
- `exc_ack_i` is ignored outside REQ; `eret_i` is ignored outside HANDLER.
- Reset asserted mid-handshake returns to IDLE on the next edge. The mask and pending bits clear too.

## Configuration
- Macro: `EXC_IRQ_LATCH_EN`.
- Defined:
  - Each `irq_i` bit is sampled every cycle; a 0→1 transition sets `pending[i]`.
  - `pending[i]` clears at the edge where `exc_ack_i` is accepted with cause = interrupt i. A new edge on that same cycle sets it again.
  - Pending bits accumulate in every state, including while masked.
- Not defined:
  - No pending register; `irq_src = irq_i`.
  - An interrupt line that drops before qualification is lost.
  - Once a request is in REQ, a dropping interrupt line does not withdraw it.

## Test plan
- Reset, then write mask = 0x0004 with `irq_enable_i` = 1, then raise `irq_i[2]` -> next cycle `exc_req_o` = 1 and `cause_o` = 0x22. Ack -> `in_handler_o` = 1. `eret_i` -> IDLE.
- `illegal_insn_i`, `ecall_insn_i` and `irq_i[0]` (enabled) raised in the same cycle -> `cause_o` = 0x02. Asserting `flush_i` before ack -> `exc_req_o` = 0 next cycle, after which the interrupt is taken with cause 0x20.
- In HANDLER, raise enabled `irq_i[1]` -> no request. Assert `eret_i` -> IDLE, then next cycle `exc_req_o` = 1 with cause 0x21 (line held high).
- In HANDLER, `ecall_insn_i` and `eret_i` in the same cycle -> REQ with cause 0x0B; `in_handler_o` = 0 while in REQ.
- In REQ, `exc_ack_i` and `flush_i` in the same cycle -> HANDLER. Assert `rst` in HANDLER -> all outputs return to their reset values next cycle.
- With `EXC_IRQ_LATCH_EN` defined: a one-cycle pulse on `irq_i[5]` while masked -> no request. Then unmask -> request with cause 0x25. Ack -> `pending[5]` cleared.
